// File: rtl/if_fetch_ctrl_pkg.sv
// Shared pipeline constants for the fetch stage: enables, stall/branch levels, bus widths.
package if_fetch_ctrl_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned RegBus      = 32;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

endpackage : if_fetch_ctrl_pkg

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, runs the req/ack instruction bus,
// delivers PC/instruction pairs to IF/ID and redirects on ID branches with delay slots.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_address_i,
    output logic                ibus_req_o,
    output logic [ADDR_W-1:0]   ibus_addr_o,
    input  logic                ibus_ack_i,
    input  logic [InstBus-1:0]  ibus_data_i,
    output logic [ADDR_W-1:0]   if_pc_o,
    output logic [InstBus-1:0]  if_inst_o,
    output logic                if_valid_o,
    output logic                stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state, state_n;
    logic                ce, ce_n;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_n;
    logic                pend_br, pend_br_n;
    logic [ADDR_W-1:0]   pend_tgt, pend_tgt_n;
    logic [ADDR_W-1:0]   buf_pc, buf_pc_n;
    logic [InstBus-1:0]  buf_inst, buf_inst_n;
    logic                req_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [ADDR_W-1:0]   pc_n;
    logic [InstBus-1:0]  inst_n;
    logic                valid_n;

    logic                hold;
    logic                accept;
    logic [ADDR_W-1:0]   br_tgt;
    logic [ADDR_W-1:0]   next_pc;
    logic                unused_bits;

    // IF stage held by CTRL this cycle
    assign hold = (stall[0] == Stop);

    // Branch target forced to a word boundary
    assign br_tgt = ADDR_W'({branch_target_address_i[31:2], 2'b00});

    // Upper stall bits belong to later stages; target low bits are discarded
    assign unused_bits = ^{stall[5:1], branch_target_address_i[1:0]};

    // Fetch is waiting on memory: ask CTRL to freeze the pipeline
    assign stallreq_o = (state == S_BUSY) && !ibus_ack_i;

    // Next fetch address: live branch, then pending branch, then sequential
    always_comb begin
        if (branch_flag_i == Branch) begin
            next_pc = br_tgt;
        end else if (pend_br) begin
            next_pc = pend_tgt;
        end else begin
            next_pc = fetch_pc + ADDR_W'(4);
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n    = state;
        ce_n       = ChipEnable;
        fetch_pc_n = fetch_pc;
        pend_br_n  = pend_br;
        pend_tgt_n = pend_tgt;
        buf_pc_n   = buf_pc;
        buf_inst_n = buf_inst;
        req_n      = ibus_req_o;
        addr_n     = ibus_addr_o;
        pc_n       = if_pc_o;
        inst_n     = if_inst_o;
        valid_n    = 1'b0;
        accept     = 1'b0;

        case (state)
            S_IDLE: begin
                if ((ce == ChipEnable) && !hold) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ibus_ack_i) begin
                    if (!hold) begin
                        accept = 1'b1;
                        pc_n   = ibus_addr_o;
                        inst_n = ibus_data_i;
                    end else begin
                        // Park the returned word until the stage is released
                        buf_pc_n   = ibus_addr_o;
                        buf_inst_n = ibus_data_i;
                        req_n      = 1'b0;
                        state_n    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!hold) begin
                    accept = 1'b1;
                    pc_n   = buf_pc;
                    inst_n = buf_inst;
                end
            end
            default: begin
                state_n = S_IDLE;
                req_n   = 1'b0;
            end
        endcase

        // A delivery always launches the next fetch on the same edge
        if (accept) begin
            valid_n    = 1'b1;
            fetch_pc_n = next_pc;
            req_n      = 1'b1;
            addr_n     = next_pc;
            state_n    = S_BUSY;
            pend_br_n  = 1'b0;
        end else if ((branch_flag_i == Branch) && !hold) begin
            // Remember the redirect until the delay slot is delivered
            pend_br_n  = 1'b1;
            pend_tgt_n = br_tgt;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state       <= S_IDLE;
            ce          <= ChipDisable;
            fetch_pc    <= RESET_PC;
            pend_br     <= 1'b0;
            pend_tgt    <= '0;
            buf_pc      <= '0;
            buf_inst    <= ZeroWord;
            ibus_req_o  <= 1'b0;
            ibus_addr_o <= '0;
            if_pc_o     <= '0;
            if_inst_o   <= ZeroWord;
            if_valid_o  <= 1'b0;
        end else begin
            state       <= state_n;
            ce          <= ce_n;
            fetch_pc    <= fetch_pc_n;
            pend_br     <= pend_br_n;
            pend_tgt    <= pend_tgt_n;
            buf_pc      <= buf_pc_n;
            buf_inst    <= buf_inst_n;
            ibus_req_o  <= req_n;
            ibus_addr_o <= addr_n;
            if_pc_o     <= pc_n;
            if_inst_o   <= inst_n;
            if_valid_o  <= valid_n;
        end
    end

endmodule : if_fetch_ctrl

// File: tb/tb_if_fetch_ctrl.sv
// Directed vector bench for the IF fetch sequencer.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_data_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        stallreq_o;

    int n_vec;
    int n_err;

    if_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_req_o              (ibus_req_o),
        .ibus_addr_o             (ibus_addr_o),
        .ibus_ack_i              (ibus_ack_i),
        .ibus_data_i             (ibus_data_i),
        .if_pc_o                 (if_pc_o),
        .if_inst_o               (if_inst_o),
        .if_valid_o              (if_valid_o),
        .stallreq_o              (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle; xs = stallreq before the edge, rest = registered outputs after it
    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        xs;
        logic        xr;
        logic [31:0] xa;
        logic [31:0] xp;
        logic [31:0] xi;
        logic        xv;
    } vec_t;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic r, input logic [5:0] s, input logic b,
                                input logic [31:0] t, input logic a, input logic [31:0] d,
                                input logic xs, input logic xr, input logic [31:0] xa,
                                input logic [31:0] xp, input logic [31:0] xi, input logic xv);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.data = d;
        v.xs = xs; v.xr = xr; v.xa = xa; v.xp = xp; v.xi = xi; v.xv = xv;
        return v;
    endfunction

    task automatic chk(input string tag, input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] %s: got %08h expected %08h", tag, idx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        rst                     = v.rst;
        stall                   = v.stall;
        branch_flag_i           = v.br;
        branch_target_address_i = v.tgt;
        ibus_ack_i              = v.ack;
        ibus_data_i             = v.data;
        #1;
        n_vec++;
        chk(tag, idx, "stallreq", 32'(stallreq_o), 32'(v.xs));
        @(posedge clk);
        #1;
        chk(tag, idx, "req",   32'(ibus_req_o), 32'(v.xr));
        chk(tag, idx, "addr",  ibus_addr_o,     v.xa);
        chk(tag, idx, "pc",    if_pc_o,         v.xp);
        chk(tag, idx, "inst",  if_inst_o,       v.xi);
        chk(tag, idx, "valid", 32'(if_valid_o), 32'(v.xv));
    endtask

    vec_t tab_a[$];
    vec_t tab_b[$];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        stall = 6'b0;
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;
        ibus_ack_i = 1'b0;
        ibus_data_i = 32'h0;

        // Reset, zero-wait, 3-cycle latency, branch in flight, branch with ack, held ack
        tab_a.push_back(mk(1,6'h00,0,32'h0,  0,32'h0,             0,0,32'h00,32'h00,32'h0,0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             0,0,32'h00,32'h00,32'h0,0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             0,1,32'h00,32'h00,32'h0,0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  1,inst_of(32'h00),   0,1,32'h04,32'h00,inst_of(32'h00),1));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  1,inst_of(32'h04),   0,1,32'h08,32'h04,inst_of(32'h04),1));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  1,inst_of(32'h08),   0,1,32'h0C,32'h08,inst_of(32'h08),1));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             1,1,32'h0C,32'h08,inst_of(32'h08),0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             1,1,32'h0C,32'h08,inst_of(32'h08),0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  1,inst_of(32'h0C),   0,1,32'h10,32'h0C,inst_of(32'h0C),1));
        tab_a.push_back(mk(0,6'h00,1,32'h40, 0,32'h0,             1,1,32'h10,32'h0C,inst_of(32'h0C),0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             1,1,32'h10,32'h0C,inst_of(32'h0C),0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  1,inst_of(32'h10),   0,1,32'h40,32'h10,inst_of(32'h10),1));
        tab_a.push_back(mk(0,6'h00,1,32'h83, 1,inst_of(32'h40),   0,1,32'h80,32'h40,inst_of(32'h40),1));
        tab_a.push_back(mk(0,6'h3E,0,32'h0,  1,inst_of(32'h80),   0,1,32'h84,32'h80,inst_of(32'h80),1));
        tab_a.push_back(mk(0,6'h01,0,32'h0,  1,inst_of(32'h84),   0,0,32'h84,32'h80,inst_of(32'h80),0));
        tab_a.push_back(mk(0,6'h01,0,32'h0,  0,32'h0,             0,0,32'h84,32'h80,inst_of(32'h80),0));
        tab_a.push_back(mk(0,6'h01,1,32'h200,0,32'h0,             0,0,32'h84,32'h80,inst_of(32'h80),0));
        tab_a.push_back(mk(0,6'h01,0,32'h0,  0,32'h0,             0,0,32'h84,32'h80,inst_of(32'h80),0));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             0,1,32'h88,32'h84,inst_of(32'h84),1));
        tab_a.push_back(mk(0,6'h00,0,32'h0,  0,32'h0,             1,1,32'h88,32'h84,inst_of(32'h84),0));

        // Restart after mid-fetch reset: stray acks, IDLE stall, wrap, overwritten pending branch
        tab_b.push_back(mk(1,6'h00,0,32'h0,       0,32'h0,               0,0,32'h0,32'h0,32'h0,0));
        tab_b.push_back(mk(0,6'h00,0,32'h0,       1,32'hDEAD_BEEF,       0,0,32'h0,32'h0,32'h0,0));
        tab_b.push_back(mk(0,6'h01,0,32'h0,       1,32'hDEAD_BEEF,       0,0,32'h0,32'h0,32'h0,0));
        tab_b.push_back(mk(0,6'h00,0,32'h0,       1,32'hDEAD_BEEF,       0,1,32'h0,32'h0,32'h0,0));
        tab_b.push_back(mk(0,6'h00,1,32'hFFFF_FFFF,1,inst_of(32'h0),     0,1,32'hFFFF_FFFC,32'h0,inst_of(32'h0),1));
        tab_b.push_back(mk(0,6'h00,0,32'h0,       1,inst_of(32'hFFFF_FFFC),0,1,32'h0,32'hFFFF_FFFC,inst_of(32'hFFFF_FFFC),1));
        tab_b.push_back(mk(0,6'h00,1,32'h100,     0,32'h0,               1,1,32'h0,32'hFFFF_FFFC,inst_of(32'hFFFF_FFFC),0));
        tab_b.push_back(mk(0,6'h00,1,32'h204,     0,32'h0,               1,1,32'h0,32'hFFFF_FFFC,inst_of(32'hFFFF_FFFC),0));
        tab_b.push_back(mk(0,6'h00,0,32'h0,       1,inst_of(32'h0),      0,1,32'h204,32'h0,inst_of(32'h0),1));

        for (int i = 0; i < tab_a.size(); i++) begin
            apply(tab_a[i], "seq", i);
        end

        // Reset while a fetch at 0x88 is outstanding: outputs clear without waiting for an edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        chk("rst_async", 0, "req",      32'(ibus_req_o), 32'h0);
        chk("rst_async", 0, "addr",     ibus_addr_o,     32'h0);
        chk("rst_async", 0, "pc",       if_pc_o,         32'h0);
        chk("rst_async", 0, "inst",     if_inst_o,       32'h0);
        chk("rst_async", 0, "valid",    32'(if_valid_o), 32'h0);
        chk("rst_async", 0, "stallreq", 32'(stallreq_o), 32'h0);

        for (int i = 0; i < tab_b.size(); i++) begin
            apply(tab_b[i], "restart", i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_if_fetch_ctrl
